vga_term_writer: RTL

//  Byte-stream terminal front end for the VGA text controller's DMA port. Consumes ASCII bytes

---
 rtl/vga_term_writer_if.sv | 29 ++
 rtl/vga_term_writer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vga_term_writer_if.sv
// Byte-stream input and VRAM/cursor output bundle between a byte source,
// vga_term_writer and vga_top.
interface vga_term_writer_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        i_data;
  logic              i_valid;
  logic              o_ready;
  logic [7:0]        i_attr;
  logic [ADDR_W-1:0] o_vram_adr;
  logic [7:0]        o_vram_data;
  logic [7:0]        o_cram_data;
  logic              o_vram_we;
  logic [ADDR_W-1:0] o_cursor_adr;
  logic              o_cursor_on;
  logic              o_busy;

  modport slave (
    input  i_data, i_valid, i_attr,
    output o_ready, o_vram_adr, o_vram_data, o_cram_data, o_vram_we,
           o_cursor_adr, o_cursor_on, o_busy
  );

  modport master (
    output i_data, i_valid, i_attr,
    input  o_ready, o_vram_adr, o_vram_data, o_cram_data, o_vram_we,
           o_cursor_adr, o_cursor_on, o_busy
  );
endinterface

// File: rtl/vga_term_writer.sv
// Terminal front end for the VGA text controller: writes printable bytes at the
// cursor, interprets CR/LF/BS/FF and blanks the screen after every reset.
//
// state   | meaning
// S_CLEAR | sweeping FILL_CHAR/DEF_ATTR over every cell, one per cycle
// S_IDLE  | ready for the next byte
// S_STEP  | one-cycle gap after an accepted byte (write strobe visible here)
module vga_term_writer #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 25,
  parameter int         ADDR_W    = 11,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter logic [7:0] DEF_ATTR  = 8'h07
) (
  input logic              i_clk,
  input logic              i_rst,
  vga_term_writer_if.slave bus
);

  localparam int CELLS = COLS * ROWS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LF_LIM  = ADDR_W'(CELLS - COLS);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(CELLS);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_STEP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  sweep_cnt, sweep_cnt_n;
  logic [ADDR_W-1:0] cursor, cursor_n;
  logic [COL_W-1:0]  col, col_n;
  logic [ADDR_W-1:0] vram_adr, vram_adr_n;
  logic [7:0]        vram_data, vram_data_n;
  logic [7:0]        cram_data, cram_data_n;
  logic              vram_we, vram_we_n;
  logic              printable;

  assign printable = (bus.i_data >= 8'h20) && (bus.i_data != 8'h7F);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_CLEAR;
      sweep_cnt <= '0;
      cursor    <= '0;
      col       <= '0;
      vram_adr  <= '0;
      vram_data <= '0;
      cram_data <= '0;
      vram_we   <= 1'b0;
    end else begin
      state     <= state_n;
      sweep_cnt <= sweep_cnt_n;
      cursor    <= cursor_n;
      col       <= col_n;
      vram_adr  <= vram_adr_n;
      vram_data <= vram_data_n;
      cram_data <= cram_data_n;
      vram_we   <= vram_we_n;
    end
  end

  // The column is tracked alongside the cursor so CR/LF never need a modulo.
  always_comb begin
    state_n     = state;
    sweep_cnt_n = sweep_cnt;
    cursor_n    = cursor;
    col_n       = col;
    vram_adr_n  = vram_adr;
    vram_data_n = vram_data;
    cram_data_n = cram_data;
    vram_we_n   = 1'b0;

    case (state)
      S_CLEAR: begin
        if (sweep_cnt == CNT_END) begin
          state_n  = S_IDLE;
          cursor_n = '0;
          col_n    = '0;
        end else begin
          vram_we_n   = 1'b1;
          vram_adr_n  = sweep_cnt[ADDR_W-1:0];
          vram_data_n = FILL_CHAR;
          cram_data_n = DEF_ATTR;
          sweep_cnt_n = sweep_cnt + CNT_W'(1);
        end
      end

      S_IDLE: begin
        if (bus.i_valid) begin
          state_n = S_STEP;
          if (printable) begin
            vram_we_n   = 1'b1;
            vram_adr_n  = cursor;
            vram_data_n = bus.i_data;
            cram_data_n = bus.i_attr;
            if (cursor == LAST) begin
              cursor_n = '0;
              col_n    = '0;
            end else begin
              cursor_n = cursor + ADDR_W'(1);
              col_n    = (col == COL_MAX) ? '0 : col + COL_W'(1);
            end
          end else begin
            case (bus.i_data)
              8'h0D: begin
                cursor_n = cursor - ADDR_W'(col);
                col_n    = '0;
              end
              8'h0A: begin
                // No scrolling: running off the bottom lands on row 0, same column.
                if (cursor < LF_LIM) cursor_n = cursor + COLS_A;
                else                 cursor_n = ADDR_W'(col);
              end
              8'h08: begin
                if (cursor != '0) begin
                  cursor_n = cursor - ADDR_W'(1);
                  col_n    = (col == '0) ? COL_MAX : col - COL_W'(1);
                end
              end
              8'h0C: begin
                state_n     = S_CLEAR;
                sweep_cnt_n = '0;
              end
              default: ;
            endcase
          end
        end
      end

      S_STEP: state_n = S_IDLE;

      default: begin
        state_n     = S_CLEAR;
        sweep_cnt_n = '0;
      end
    endcase
  end

  assign bus.o_ready      = (state == S_IDLE);
  assign bus.o_busy       = (state == S_CLEAR);
  assign bus.o_cursor_on  = (state != S_CLEAR);
  assign bus.o_cursor_adr = cursor;
  assign bus.o_vram_adr   = vram_adr;
  assign bus.o_vram_data  = vram_data;
  assign bus.o_cram_data  = cram_data;
  assign bus.o_vram_we    = vram_we;

endmodule
